hs_rr_arbiter: RTL and testbench

- N-input round-robin arbiter that shares one valid/ready output channel among N valid/ready requesters.
- Packet-aware: once a requester wins with a non-last beat, the grant is held until that requester's last beat is accepted.
- Output is fully registered through an output register plus a skid slot, giving full throughput and 1-cycle latency.
- Sits between several producer stages and a single downstream pipeline stage or shared resource.

---
 rtl/hs_rr_arbiter_pkg.sv | 22 ++
 rtl/hs_rr_arbiter_skid_buf.sv | 53 +++++
 rtl/hs_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_hs_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_rr_arbiter_pkg.sv
// Shared types and width helpers for the handshake round-robin arbiter.
package hs_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } hs_state_e;

  // Ceiling log2, usable in constant (parameter) context.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Source-index width; a single requester still needs a 1-bit field.
  function automatic int src_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_skid_buf.sv
// Output register plus one skid slot. The register is the exposed entry;
// the skid slot absorbs the one beat that can arrive in the cycle a stall
// is first seen, because in_ready is registered (derived from skid_full).
module hs_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_full;
  logic [W-1:0] r_skid_data;
  logic         w_in_fire;
  logic         w_load;

  assign in_ready  = !r_skid_full;
  assign w_in_fire = in_valid & !r_skid_full;
  assign w_load    = !r_out_valid | out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Refill the output register from the skid slot first, then from the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_full <= 1'b0;
      r_skid_data <= '0;
    end else if (w_load) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_skid_full <= w_in_fire;
        if (w_in_fire) r_skid_data <= in_data;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out_data <= in_data;
      end
    end else if (w_in_fire) begin
      r_skid_full <= 1'b1;
      r_skid_data <= in_data;
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Packet-aware round-robin arbiter: N valid/ready requesters share one
// registered valid/ready output. A winner sending a non-last beat keeps the
// grant until its last beat is accepted.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DATA_W = 8,
  localparam int SRC_W  = src_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          valid_pre_i,
  input  logic [N*DATA_W-1:0]   data_pre_i,
  input  logic [N-1:0]          last_pre_i,
  output logic [N-1:0]          ready_pre_o,
  output logic                  valid_post_o,
  output logic [DATA_W-1:0]     data_post_o,
  output logic                  last_post_o,
  output logic [SRC_W-1:0]      src_post_o,
  input  logic                  ready_post_i
);

  localparam int BW = DATA_W + 1 + SRC_W;

  hs_state_e          r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SRC_W-1:0]   r_owner, w_owner_nxt;
  logic [SRC_W-1:0]   w_pick;
  logic [SRC_W-1:0]   w_pick_inc;
  logic               w_found;
  logic               r_en;
  logic               w_in_ready;
  logic               w_acc;
  logic               w_last;
  logic [DATA_W-1:0]  w_data;
  logic [BW-1:0]      w_beat;
  logic [BW-1:0]      w_out;

  // Pick: locked owner only, else first valid requester at or after ptr.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_s;
    idx     = 0;
    idx_s   = '0;
    w_pick  = r_ptr;
    w_found = 1'b0;
    if (r_state == LOCKED) begin
      w_pick  = r_owner;
      w_found = valid_pre_i[r_owner];
    end else begin
      // Descending scan so the lowest rotated offset is the last writer.
      for (int i = N - 1; i >= 0; i--) begin
        idx   = (int'(r_ptr) + i) % N;
        idx_s = SRC_W'(idx);
        if (valid_pre_i[idx_s]) begin
          w_pick  = idx_s;
          w_found = 1'b1;
        end
      end
    end
  end

  // Payload/last mux for the picked requester.
  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (SRC_W'(k) == w_pick) begin
        w_data = data_pre_i[k*DATA_W +: DATA_W];
        w_last = last_pre_i[k];
      end
    end
  end

  // One-hot ready; r_en keeps every ready low in the first cycle after reset.
  always_comb begin
    ready_pre_o = '0;
    for (int k = 0; k < N; k++)
      ready_pre_o[k] = (SRC_W'(k) == w_pick) & w_found & w_in_ready & r_en;
  end

  assign w_acc      = w_found & w_in_ready & r_en;
  assign w_pick_inc = (w_pick == SRC_W'(N - 1)) ? '0 : w_pick + 1'b1;

  // Next state: lock on a non-last beat, release and rotate on a last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (w_acc) begin
      if (w_last) begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = w_pick_inc;
      end else begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_pick;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_en    <= 1'b1;
    end
  end

  assign w_beat = {w_pick, w_last, w_data};

  hs_skid_buf #(.W(BW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_acc),
    .in_ready  (w_in_ready),
    .in_data   (w_beat),
    .out_valid (valid_post_o),
    .out_ready (ready_post_i),
    .out_data  (w_out)
  );

  assign {src_post_o, last_post_o, data_post_o} = w_out;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed scenarios followed by random traffic, all cross-checked every
// cycle against a queue-level model: a 2-deep output buffer that accepts
// only when not full at cycle start, plus rotate/lock grant rules.
module tb_hs_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid_pre_i;
  logic [N*DW-1:0] data_pre_i;
  logic [N-1:0]    last_pre_i;
  logic [N-1:0]    ready_pre_o;
  logic            valid_post_o;
  logic [DW-1:0]   data_post_o;
  logic            last_post_o;
  logic [1:0]      src_post_o;
  logic            ready_post_i;

  hs_rr_arbiter #(.N(N), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_pre_i  (valid_pre_i),
    .data_pre_i   (data_pre_i),
    .last_pre_i   (last_pre_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .data_post_o  (data_post_o),
    .last_post_o  (last_post_o),
    .src_post_o   (src_post_o),
    .ready_post_i (ready_post_i)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  beat_t q[$];
  beat_t obs_q[$];
  int    m_ptr = 0, m_owner = 0;
  bit    m_locked = 0, m_warm = 0, mdl_on = 0;
  int    acc_k = -1;

  // Observations from the most recent tick
  logic [N-1:0] obs_rdy;
  logic         obs_vld;
  logic [7:0]   obs_data;
  logic [1:0]   obs_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic v, input logic [7:0] d, input logic l);
    valid_pre_i[k]        = v;
    data_pre_i[k*DW +: DW] = d;
    last_pre_i[k]         = l;
  endtask

  // One clock: check at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    logic [N-1:0] er;
    bit           found;
    beat_t        nb;
    int           k;
    @(negedge clk);
    obs_rdy  = ready_pre_o;
    obs_vld  = valid_post_o;
    obs_data = data_post_o;
    obs_src  = src_post_o;
    if (obs_vld === 1'b1) obs_q.push_back('{int'(obs_src), obs_data, last_post_o});
    er = '0;
    k  = -1;
    if (mdl_on) begin
      if (m_warm && q.size() < 2) begin
        if (m_locked) begin
          if (valid_pre_i[m_owner]) k = m_owner;
        end else begin
          found = 0;
          for (int i = 0; i < N; i++)
            if (!found && valid_pre_i[(m_ptr + i) % N]) begin
              k = (m_ptr + i) % N;
              found = 1;
            end
        end
      end
      if (k >= 0) er[k] = 1'b1;
      chk("ready_pre", ready_pre_o, er);
      chk("valid_post", valid_post_o, q.size() > 0);
      if (q.size() > 0) begin
        chk("data_post", data_post_o, q[0].data);
        chk("last_post", last_post_o, q[0].last);
        chk("src_post", src_post_o, q[0].src);
      end
      if (k >= 0) nb = '{k, data_pre_i[k*DW +: DW], last_pre_i[k]};
    end
    @(posedge clk);
    acc_k = -1;
    if (rst) begin
      q.delete();
      m_ptr = 0; m_owner = 0; m_locked = 0; m_warm = 0; mdl_on = 1;
    end else if (mdl_on) begin
      if (q.size() > 0 && ready_post_i) void'(q.pop_front());
      if (k >= 0) begin
        acc_k = k;
        q.push_back(nb);
        if (nb.last) begin
          m_locked = 0;
          m_ptr    = (k + 1) % N;
        end else begin
          m_locked = 1;
          m_owner  = k;
        end
      end
      m_warm = 1;
    end
    #1;
  endtask

  task automatic drain();
    valid_pre_i  = '0;
    ready_post_i = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int   b2, nacc;
    logic [7:0] held;

    // 1: reset with every requester valid
    rst = 1'b1; ready_post_i = 1'b1;
    for (int k = 0; k < N; k++) put(k, 1'b1, 8'(8'h10 + k), 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", obs_vld, 0);
    chk("rst_ready", obs_rdy, 4'b0000);
    chk("rst_src", obs_src, 0);

    // 2: fair rotation, single-beat packets, no gaps
    tick();
    chk("rot_first_vld", obs_vld, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot_vld", obs_vld, 1);
      chk("rot_src", obs_src, i % 4);
      chk("rot_data", obs_data, 8'h10 + (i % 4));
    end

    // 3: packet lock on requester 2 while requester 0 waits
    drain();
    put(0, 1'b1, 8'h10, 1'b1);
    put(2, 1'b1, 8'hA0, 1'b0);
    b2 = 0;
    obs_q.delete();
    for (int c = 0; c < 20 && obs_q.size() < 4; c++) begin
      tick();
      if (b2 < 3) chk("lock_rdy0", obs_rdy[0], 0);
      if (acc_k == 2) begin
        b2++;
        if (b2 < 3) put(2, 1'b1, 8'(8'hA0 + b2), b2 == 2);
        else valid_pre_i[2] = 1'b0;
      end
      if (acc_k == 0) valid_pre_i[0] = 1'b0;
    end
    chk("lock_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      chk("lock_b0", {obs_q[0].src, 8'(obs_q[0].data)}, {32'd2, 8'hA0});
      chk("lock_b1", {obs_q[1].src, 8'(obs_q[1].data)}, {32'd2, 8'hA1});
      chk("lock_b2", {obs_q[2].src, 8'(obs_q[2].data)}, {32'd2, 8'hA2});
      chk("lock_b3", obs_q[3].src, 0);
    end

    // 4: backpressure mid-stream
    drain();
    for (int k = 0; k < N; k++) put(k, 1'b1, 8'(8'h10 + k), 1'b1);
    repeat (4) tick();
    ready_post_i = 1'b0;
    nacc = 0;
    held = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc_k >= 0) nacc++;
      if (i == 0) held = obs_data;
      else begin
        chk("bp_hold", obs_data, held);
        chk("bp_vld", obs_vld, 1);
        chk("bp_rdy", obs_rdy, 4'b0000);
      end
    end
    chk("bp_absorb", nacc, 1);
    ready_post_i = 1'b1;
    repeat (6) tick();

    // 5: pointer wrap from 3 to requester 1
    drain();
    put(2, 1'b1, 8'h52, 1'b1);
    tick();
    chk("wrap_setup", obs_rdy, 4'b0100);
    valid_pre_i = '0;
    put(1, 1'b1, 8'h51, 1'b1);
    tick();
    chk("wrap_rdy", obs_rdy, 4'b0010);
    valid_pre_i = '0;
    put(0, 1'b1, 8'h50, 1'b1);
    put(2, 1'b1, 8'h52, 1'b1);
    tick();
    chk("wrap_src", {obs_vld, obs_src}, {1'b1, 2'd1});
    chk("wrap_next", obs_rdy, 4'b0100);

    // 6: reset while locked to owner 2
    drain();
    put(2, 1'b1, 8'hB0, 1'b0);
    tick();
    put(2, 1'b1, 8'hB1, 1'b0);
    put(0, 1'b1, 8'hC0, 1'b1);
    put(1, 1'b1, 8'hC1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rstpk_vld", obs_vld, 0);
    chk("rstpk_rdy", obs_rdy, 4'b0000);
    tick();
    chk("rstpk_grant", obs_rdy, 4'b0001);
    if (acc_k == 0) valid_pre_i[0] = 1'b0;
    tick();
    chk("rstpk_out", {obs_vld, obs_src, obs_data}, {1'b1, 2'd0, 8'hC0});

    // Random traffic; a presented beat is held until accepted
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (acc_k == k) valid_pre_i[k] = 1'b0;
        if (!valid_pre_i[k] && $urandom_range(0, 2) != 0)
          put(k, 1'b1, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
      end
      ready_post_i = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
